// File: rtl/seq_pkg.sv
// Shared encodings for the parametrised serial pattern detector.
package seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_e;

   localparam logic MODE_NOVL = 1'b0;
   localparam logic MODE_OVL  = 1'b1;

   localparam logic FOUND     = 1'b1;
   localparam logic NOTFOUND  = 1'b0;

endpackage : seq_pkg

// File: rtl/seq_detector_param_if.sv
// Serial stream, pattern-load and detection-result bundle of the detector.
interface seq_detector_param_if #(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned LEN_W = 4,
   parameter int unsigned CNT_W = 8
) ();

   logic             x;
   logic             valid;
   logic             load;
   logic [PAT_W-1:0] pat;
   logic [LEN_W-1:0] len;
   logic             mode;
   logic             found;
   logic [CNT_W-1:0] count;
   logic             armed;

   modport master (
      output x, valid, load, pat, len, mode,
      input  found, count, armed
   );

   modport slave (
      input  x, valid, load, pat, len, mode,
      output found, count, armed
   );

endinterface : seq_detector_param_if

// File: rtl/seq_window_cmp.sv
// Compares the low len_r bits of the next history word against the pattern,
// qualified by enough valid history being present.
module seq_window_cmp #(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned LEN_W = 4,
   parameter int unsigned FILL_W = 4
) (
   input  logic [PAT_W-1:0]  hist_n,
   input  logic [PAT_W-1:0]  pat_r,
   input  logic [LEN_W-1:0]  len_r,
   input  logic [FILL_W-1:0] fill_n,
   output logic              match_c
);

   logic [PAT_W-1:0] mask_c;

   // Thermometer mask selecting bit positions below len_r.
   always_comb begin
      mask_c = '0;
      for (int unsigned i = 0; i < PAT_W; i++) begin
         mask_c[i] = (i < 32'(len_r));
      end
   end

   // Masked equality plus history-depth qualifier.
   always_comb begin
      match_c = (32'(fill_n) >= 32'(len_r)) &&
                (((hist_n ^ pat_r) & mask_c) == '0);
   end

endmodule : seq_window_cmp

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control and a
// saturating match counter.
module seq_detector_param
   import seq_pkg::*;
#(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned LEN_W = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   seq_detector_param_if.slave  bus
);

   localparam int unsigned FILL_W = $clog2(PAT_W + 1);

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               mode_q, mode_d;
   logic [PAT_W-1:0]   hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic               found_q, found_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [LEN_W-1:0]   len_clamp_c;
   logic [PAT_W-1:0]   hist_n;
   logic [FILL_W-1:0]  fill_n;
   logic               match_c;

   // Clamp the requested length into 1..PAT_W.
   always_comb begin
      len_clamp_c = bus.len;
      if (bus.len == '0) begin
         len_clamp_c = LEN_W'(1);
      end else if (32'(bus.len) > PAT_W) begin
         len_clamp_c = LEN_W'(PAT_W);
      end
   end

   // Candidate history and fill level if this edge takes a sample.
   always_comb begin
      hist_n = (hist_q << 1) | PAT_W'(bus.x);
      fill_n = (32'(fill_q) >= PAT_W) ? fill_q : fill_q + FILL_W'(1);
   end

   seq_window_cmp #(
      .PAT_W  (PAT_W),
      .LEN_W  (LEN_W),
      .FILL_W (FILL_W)
   ) u_cmp (
      .hist_n  (hist_n),
      .pat_r   (pat_q),
      .len_r   (len_q),
      .fill_n  (fill_n),
      .match_c (match_c)
   );

   // Next-state logic: load has priority over sampling; IDLE ignores data.
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      mode_d  = mode_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      found_d = NOTFOUND;
      count_d = count_q;

      if (bus.load) begin
         state_d = ST_SCAN;
         pat_d   = bus.pat;
         len_d   = len_clamp_c;
         mode_d  = bus.mode;
         hist_d  = '0;
         fill_d  = '0;
         count_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_SCAN: begin
               if (bus.valid) begin
                  hist_d = hist_n;
                  fill_d = fill_n;
                  if (match_c) begin
                     found_d = FOUND;
                     if (count_q != '1) begin
                        count_d = count_q + CNT_W'(1);
                     end
                     if (mode_q == MODE_NOVL) begin
                        fill_d = '0;
                     end
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pat_q   <= '0;
         len_q   <= LEN_W'(1);
         mode_q  <= MODE_NOVL;
         hist_q  <= '0;
         fill_q  <= '0;
         found_q <= NOTFOUND;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         mode_q  <= mode_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         found_q <= found_d;
         count_q <= count_d;
      end
   end

   assign bus.found = found_q;
   assign bus.count = count_q;
   assign bus.armed = (state_q == ST_SCAN);

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: hand-derived vector table, reset and
// saturation sequences, then randomized traffic against a queue model.
module tb_seq_detector_param;

   localparam int unsigned PAT_W = 8;
   localparam int unsigned LEN_W = 4;
   localparam int unsigned CNT_W = 8;
   localparam int          CNT_MAX = 255;

   logic clk;
   logic reset;

   seq_detector_param_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) b1 ();
   seq_detector_param_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(2))     b2 ();

   seq_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b1)
   );

   seq_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (b2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: a queue of usable bits since the last load (or last
   // non-overlapping match); a match is the tail of the queue equal to the pattern.
   bit       q[$];
   bit [7:0] m_pat;
   int       m_len;
   bit       m_mode;
   bit       m_armed;
   bit       m_found;
   int       m_count;

   task automatic model_reset();
      q.delete();
      m_pat = '0; m_len = 1; m_mode = 1'b0;
      m_armed = 1'b0; m_found = 1'b0; m_count = 0;
   endtask

   function automatic bit tail_matches();
      bit ok = 1'b1;
      for (int i = 0; i < m_len; i++) begin
         if (q[q.size() - 1 - i] != m_pat[i]) ok = 1'b0;
      end
      return ok;
   endfunction

   task automatic model_step(input bit l, input bit v, input bit xx,
                             input bit [7:0] p, input bit [3:0] ln, input bit md);
      m_found = 1'b0;
      if (l) begin
         m_armed = 1'b1;
         m_pat   = p;
         m_len   = (ln == 0) ? 1 : ((int'(ln) > int'(PAT_W)) ? int'(PAT_W) : int'(ln));
         m_mode  = md;
         q.delete();
         m_count = 0;
      end else if (m_armed && v) begin
         q.push_back(xx);
         if (q.size() > int'(PAT_W)) void'(q.pop_front());
         if (q.size() >= m_len && tail_matches()) begin
            m_found = 1'b1;
            if (m_count < CNT_MAX) m_count++;
            if (!m_mode) q.delete();
         end
      end
   endtask

   // Drive one cycle on dut, advance the model, and return #1 after the edge.
   task automatic apply(input bit l, input bit v, input bit xx,
                        input bit [7:0] p, input bit [3:0] ln, input bit md);
      @(negedge clk);
      b1.load = l; b1.valid = v; b1.x = xx; b1.pat = p; b1.len = ln; b1.mode = md;
      @(posedge clk);
      model_step(l, v, xx, p, ln, md);
      #1;
   endtask

   task automatic apply2(input bit l, input bit v, input bit xx,
                         input bit [7:0] p, input bit [3:0] ln, input bit md);
      @(negedge clk);
      b2.load = l; b2.valid = v; b2.x = xx; b2.pat = p; b2.len = ln; b2.mode = md;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit       load;
      bit       valid;
      bit       x;
      bit [7:0] pat;
      bit [3:0] len;
      bit       mode;
      bit       exp_found;
      bit [7:0] exp_count;
      bit       exp_armed;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit l, bit v, bit xx, bit [7:0] p, bit [3:0] ln, bit md,
                               bit ef, bit [7:0] ec, bit ea);
      vec_t r;
      r.load = l; r.valid = v; r.x = xx; r.pat = p; r.len = ln; r.mode = md;
      r.exp_found = ef; r.exp_count = ec; r.exp_armed = ea;
      return r;
   endfunction

   initial begin
      reset = 1'b0;
      b1.load = 0; b1.valid = 0; b1.x = 0; b1.pat = '0; b1.len = '0; b1.mode = 0;
      b2.load = 0; b2.valid = 0; b2.x = 0; b2.pat = '0; b2.len = '0; b2.mode = 0;
      model_reset();

      // IDLE: x=0 would match the reset pattern bit if data were not ignored.
      vecs.push_back(mk(0,1,0, 8'h00,0,0, 0,0,0));
      vecs.push_back(mk(0,1,0, 8'h00,0,0, 0,0,0));
      // 1011, overlapping
      vecs.push_back(mk(1,0,0, 8'h0B,4,1, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,1, 0,0,1));
      vecs.push_back(mk(0,1,0, 8'h0B,4,1, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,1, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,1, 1,1,1));
      vecs.push_back(mk(0,1,0, 8'h0B,4,1, 0,1,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,1, 0,1,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,1, 1,2,1));
      // 1011, non-overlapping
      vecs.push_back(mk(1,0,0, 8'h0B,4,0, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,0, 0,0,1));
      vecs.push_back(mk(0,1,0, 8'h0B,4,0, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,0, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,0, 1,1,1));
      vecs.push_back(mk(0,1,0, 8'h0B,4,0, 0,1,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,0, 0,1,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,0, 0,1,1));
      // 11, overlapping
      vecs.push_back(mk(1,0,0, 8'h03,2,1, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h03,2,1, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h03,2,1, 1,1,1));
      vecs.push_back(mk(0,1,1, 8'h03,2,1, 1,2,1));
      vecs.push_back(mk(0,1,1, 8'h03,2,1, 1,3,1));
      // 11, non-overlapping
      vecs.push_back(mk(1,0,0, 8'h03,2,0, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h03,2,0, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h03,2,0, 1,1,1));
      vecs.push_back(mk(0,1,1, 8'h03,2,0, 0,1,1));
      vecs.push_back(mk(0,1,1, 8'h03,2,0, 1,2,1));
      // 1011 with valid=0 gaps carrying toggling x
      vecs.push_back(mk(1,0,0, 8'h0B,4,0, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,0, 0,0,1));
      vecs.push_back(mk(0,0,0, 8'h0B,4,0, 0,0,1));
      vecs.push_back(mk(0,1,0, 8'h0B,4,0, 0,0,1));
      vecs.push_back(mk(0,0,1, 8'h0B,4,0, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,0, 0,0,1));
      vecs.push_back(mk(0,0,0, 8'h0B,4,0, 0,0,1));
      vecs.push_back(mk(0,0,1, 8'h0B,4,0, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h0B,4,0, 1,1,1));
      vecs.push_back(mk(0,0,0, 8'h0B,4,0, 0,1,1));
      // len=0 loads as 1
      vecs.push_back(mk(1,0,0, 8'h01,0,0, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h01,0,0, 1,1,1));
      vecs.push_back(mk(0,1,0, 8'h01,0,0, 0,1,1));
      vecs.push_back(mk(0,1,1, 8'h01,0,0, 1,2,1));
      // len=15 loads as 8: pattern 10110011
      vecs.push_back(mk(1,0,0, 8'hB3,15,1, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'hB3,15,1, 0,0,1));
      vecs.push_back(mk(0,1,0, 8'hB3,15,1, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'hB3,15,1, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'hB3,15,1, 0,0,1));
      vecs.push_back(mk(0,1,0, 8'hB3,15,1, 0,0,1));
      vecs.push_back(mk(0,1,0, 8'hB3,15,1, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'hB3,15,1, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'hB3,15,1, 1,1,1));
      // load drops a same-cycle valid bit; len=1 then matches each 1
      vecs.push_back(mk(1,1,1, 8'h01,1,1, 0,0,1));
      vecs.push_back(mk(0,1,1, 8'h01,1,1, 1,1,1));
      vecs.push_back(mk(0,1,1, 8'h01,1,1, 1,2,1));
      vecs.push_back(mk(0,1,0, 8'h01,1,1, 0,2,1));

      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst found", 32'(b1.found), 32'(0));
      check("rst count", 32'(b1.count), 32'(0));
      check("rst armed", 32'(b1.armed), 32'(0));
      check("rst2 count", 32'(b2.count), 32'(0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].load, vecs[i].valid, vecs[i].x, vecs[i].pat, vecs[i].len, vecs[i].mode);
         check($sformatf("vec%0d found", i), 32'(b1.found), 32'(vecs[i].exp_found));
         check($sformatf("vec%0d count", i), 32'(b1.count), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d armed", i), 32'(b1.armed), 32'(vecs[i].exp_armed));
      end

      // Asynchronous reset right after a match clears outputs before any edge.
      apply(1,0,0, 8'h0B,4,1);
      apply(0,1,1, 8'h0B,4,1);
      apply(0,1,0, 8'h0B,4,1);
      apply(0,1,1, 8'h0B,4,1);
      apply(0,1,1, 8'h0B,4,1);
      check("pre-rst found", 32'(b1.found), 32'(1));
      check("pre-rst count", 32'(b1.count), 32'(1));
      #2 reset = 1'b0;
      #1;
      check("async found", 32'(b1.found), 32'(0));
      check("async count", 32'(b1.count), 32'(0));
      check("async armed", 32'(b1.armed), 32'(0));
      model_reset();
      @(negedge clk) reset = 1'b1;

      // Reset after three bits of 1011: the fourth bit alone must not match.
      apply(1,0,0, 8'h0B,4,1);
      apply(0,1,1, 8'h0B,4,1);
      apply(0,1,0, 8'h0B,4,1);
      apply(0,1,1, 8'h0B,4,1);
      #2 reset = 1'b0;
      #1;
      check("mid armed", 32'(b1.armed), 32'(0));
      model_reset();
      @(negedge clk) reset = 1'b1;
      apply(0,1,1, 8'h0B,4,1);
      check("noload found", 32'(b1.found), 32'(0));
      check("noload armed", 32'(b1.armed), 32'(0));
      apply(1,0,0, 8'h0B,4,1);
      check("reload armed", 32'(b1.armed), 32'(1));
      apply(0,1,1, 8'h0B,4,1);
      check("reload found", 32'(b1.found), 32'(0));
      check("reload count", 32'(b1.count), 32'(0));

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         bit       l, v, xx, md;
         bit [7:0] p;
         bit [3:0] ln;
         l  = ($urandom_range(0, 19) == 0);
         v  = ($urandom_range(0, 3) != 0);
         xx = 1'($urandom_range(0, 1));
         p  = 8'($urandom);
         ln = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
         md = 1'($urandom_range(0, 1));
         apply(l, v, xx, p, ln, md);
         check($sformatf("rnd%0d found", n), 32'(b1.found), 32'(m_found));
         check($sformatf("rnd%0d count", n), 32'(b1.count), 32'(m_count));
         check($sformatf("rnd%0d armed", n), 32'(b1.armed), 32'(m_armed));
      end

      // 2-bit counter saturation with len=1 overlapping.
      @(negedge clk);
      b1.load = 0; b1.valid = 0;
      apply2(1,0,0, 8'h01,1,1);
      check("sat armed", 32'(b2.armed), 32'(1));
      begin
         int exp_cnt[5] = '{1, 2, 3, 3, 3};
         for (int k = 0; k < 5; k++) begin
            apply2(0,1,1, 8'h01,1,1);
            check($sformatf("sat%0d found", k), 32'(b2.found), 32'(1));
            check($sformatf("sat%0d count", k), 32'(b2.count), 32'(exp_cnt[k]));
         end
      end
      apply2(0,0,0, 8'h01,1,1);
      check("sat idle found", 32'(b2.found), 32'(0));
      check("sat hold count", 32'(b2.count), 32'(3));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_seq_detector_param

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector, successor to the fixed-pattern sequence-detector FSMs. It samples a 1-bit serial stream qualified by `valid` and compares the most recent `len` bits against a runtime-loaded pattern of up to `PAT_W` bits. Each detection produces a one-cycle `found` pulse and increments a saturating match counter. Overlapping or non-overlapping detection is selected per load.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits (≥2).
- `LEN_W`, default 4: width of `len`; must satisfy 2^LEN_W > PAT_W.
- `CNT_W`, default 8: match counter width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low.
- `x`  in  1  serial data bit.
- `valid`  in  1  `x` is sampled only on edges where `valid`=1.
- `load`  in  1  latch `pat`/`len`/`mode` and restart detection.
- `pat`  in  PAT_W  pattern; `pat[len-1]` is the first bit received, `pat[0]` the last.
- `len`  in  LEN_W  pattern length.
- `mode`  in  1  0 = non-overlapping, 1 = overlapping.
- `found`  out  1  registered one-cycle match pulse.
- `count`  out  CNT_W  number of matches since last load/reset, saturating.
- `armed`  out  1  1 when in SCAN (a pattern is loaded).

## Operation
- Registers: `state`, `pat_r`, `len_r`, `mode_r`, `hist[PAT_W-1:0]`, `fill` (0..PAT_W), `found`, `count`.
- Reset (async, `reset`=0) sets: state=IDLE, `pat_r`=0, `len_r`=1, `mode_r`=0, `hist`=0, `fill`=0, `found`=0, `count`=0, `armed`=0.
- State IDLE: `valid`/`x` are ignored and `found`=0. `load`=1 moves to SCAN.
- State SCAN: `load`=1 stays in SCAN with new parameters. No other exit except reset.
- Load (any state): `pat_r`←`pat`, `mode_r`←`mode`, `len_r`←clamp(`len`).
  - Clamp: 0→1; values >PAT_W→PAT_W.
  - Clears `hist`, `fill`, `count`; `found`←0.
  - `load` has priority: a `valid` bit in the same cycle is dropped.
- Sample (SCAN, `valid`=1, `load`=0):
  - hist_n = {hist[PAT_W-2:0], x}.
  - fill_n = min(fill+1, PAT_W).
  - match = (fill_n ≥ `len_r`) && (hist_n[len_r-1:0] == pat_r[len_r-1:0]).
- On match:
  - `found`←1.
  - `count`←count+1, holding at 2^CNT_W−1.
  - If `mode_r`=0, `fill`←0 so matched bits cannot be reused; `hist` keeps its shifted value.
  - If `mode_r`=1, `fill` is updated normally.
- When no match occurs or no sample is taken: `found`←0; `hist`/`fill` hold on edges with `valid`=0.

## Timing
- Latency 0: `found` rises on the same edge that samples the last pattern bit and is high for exactly one cycle. Back-to-back matches give a continuous high `found`.
- `count` updates on the same edge as `found`.
- `armed` rises on the edge that captures `load`.
- A new pattern takes effect from the first sample after the load edge. A match completing in the load cycle is lost.
- Reset mid-stream takes effect immediately (asynchronous). The first `load` after reset release is required before any detection.
- `len_r`=1 matches every sampled bit equal to `pat_r[0]`, in either mode.

## Structure
- Shared package/header `seq_pkg`:
  - state encodings `ST_IDLE`=1'b0, `ST_SCAN`=1'b1;
  - `MODE_NOVL`=0, `MODE_OVL`=1;
  - `FOUND`=1, `NOTFOUND`=0.
- Sub-module `seq_window_cmp`: combinational masked compare of `hist_n` vs `pat_r` over `len_r` bits, plus the `fill_n ≥ len_r` qualifier; outputs `match`.
- Top module holds the FSM, registers, clamp logic and counter.

## Test plan
- Load `pat`=4'b1011, `len`=4, `mode`=1; stream 1,0,1,1,0,1,1 (all valid) → `found` pulses on samples 4 and 7; `count`=2.
- Same stream with `mode`=0 → `found` only on sample 4; `count`=1.
- `pat`=2'b11, `len`=2; stream 1,1,1,1 → overlapping gives 3 pulses; non-overlapping gives 2 pulses (samples 2 and 4).
- Insert `valid`=0 gaps with `x` toggling between the bits of 1011 → detection unaffected; `found` only on the 4th valid sample.
- CNT_W=2, overlapping `len`=1, `pat`=1, five valid 1s → `count` reads 1,2,3,3,3; `found` high all five cycles.
- Assert `reset`=0 after three bits of 1011, then release and reload → outputs 0 immediately, `armed`=0; the 4th bit alone gives no match. `len`=0 loads as 1; `len`=15 with PAT_W=8 loads as 8.
